// File: rtl/fifo_sync_prog.sv
// fifo_sync_prog: single-clock elastic buffer with programmable almost-full /
// almost-empty thresholds, standard or first-word-fall-through read mode,
// synchronous flush, occupancy count and support for any depth >= 2.
//
// Ports:
//   clk         clock, all state changes on the rising edge
//   rst         synchronous active-high reset (priority over everything)
//   flush       synchronous clear of pointers/count and status pulses
//   data_in     write data
//   wr_en       write request, accepted when not full
//   rd_en       read request (pop in FWFT mode), accepted when not empty
//   af_thresh   almost-full threshold  (almostfull  = count >= af_thresh)
//   ae_thresh   almost-empty threshold (almostempty = count <= ae_thresh)
//   data_out    read data (registered in standard mode, head word in FWFT)
//   wr_ack      pulse: write accepted on the previous edge
//   overflow    pulse: write rejected on the previous edge (was full)
//   underflow   pulse: read rejected on the previous edge (was empty)
//   full/empty  occupancy decodes
//   almostfull/almostempty  threshold decodes
//   count       current occupancy
module fifo_sync_prog #(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FWFT       = 0,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH),
  localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [CW-1:0]         af_thresh,
  input  logic [CW-1:0]         ae_thresh,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CW-1:0]         count
);

  logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [FIFO_WIDTH-1:0] r_dout;
  logic                  r_wr_ack;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic [CW-1:0]         w_count_nxt;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    if (p == AW'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + AW'(1);
  endfunction

  // All status is decoded from the count register alone, so flags are
  // glitch-free and move one cycle after the causing edge.
  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_wr_ok = wr_en & ~w_full;
  assign w_rd_ok = rd_en & ~w_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage has no reset: contents survive rst/flush, only pointers clear.
  always_ff @(posedge clk) begin
    if (!rst && !flush && w_wr_ok) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_dout      <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (flush) begin
      // Standard-mode read data deliberately holds across a flush.
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_wr_ack    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
        r_dout   <= r_mem[r_rd_ptr];
      end
      r_count     <= w_count_nxt;
      r_wr_ack    <= w_wr_ok;
      r_overflow  <= wr_en & w_full;
      r_underflow <= rd_en & w_empty;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero so an empty FIFO reads 0.
      assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      assign data_out = r_dout;
    end
  endgenerate

  assign wr_ack      = r_wr_ack;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign full        = w_full;
  assign empty       = w_empty;
  assign almostfull  = (r_count >= af_thresh);
  assign almostempty = (r_count <= ae_thresh);
  assign count       = r_count;

endmodule
